// File: rtl/iob_iob2axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_iob2axil_pkg
// Description : Shared FSM state encoding and AXI response codes for the
//               IOb-native to AXI4-Lite bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_iob2axil_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_write = 3'd1;
    localparam logic [2:0] c_st_wresp = 3'd2;
    localparam logic [2:0] c_st_read  = 3'd3;
    localparam logic [2:0] c_st_rdata = 3'd4;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    // Anything other than OKAY (including EXOKAY) counts as an error here.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != c_resp_okay;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_iob2axil.sv
`default_nettype none
// ============================================================================
// Module      : iob_iob2axil
// Description : Single-outstanding IOb-native to AXI4-Lite master bridge.
//               Define IOB_IOB2AXIL_ERR_EN to add the sticky err_o output.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_iob2axil
    import iob_iob2axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  cke_i,

    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,

    output logic [ADDR_W-1:0]     m_axil_awaddr_o,
    output logic [2:0]            m_axil_awprot_o,
    output logic                  m_axil_awvalid_o,
    input  logic                  m_axil_awready_i,
    output logic [DATA_W-1:0]     m_axil_wdata_o,
    output logic [DATA_W/8-1:0]   m_axil_wstrb_o,
    output logic                  m_axil_wvalid_o,
    input  logic                  m_axil_wready_i,
    input  logic [1:0]            m_axil_bresp_i,
    input  logic                  m_axil_bvalid_i,
    output logic                  m_axil_bready_o,
    output logic [ADDR_W-1:0]     m_axil_araddr_o,
    output logic [2:0]            m_axil_arprot_o,
    output logic                  m_axil_arvalid_o,
    input  logic                  m_axil_arready_i,
    input  logic [DATA_W-1:0]     m_axil_rdata_i,
    input  logic [1:0]            m_axil_rresp_i,
    input  logic                  m_axil_rvalid_i,
    output logic                  m_axil_rready_o
`ifdef IOB_IOB2AXIL_ERR_EN
    ,
    output logic                  err_o
`endif
);

    state_t                r_state;
    logic [ADDR_W-1:2]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_is_write;
    logic                  w_aw_done;
    logic                  w_w_done;

    assign w_is_write = |iob_wstrb_i;
    // A channel is finished once its valid has dropped or it handshakes now.
    assign w_aw_done  = !r_awvalid || m_axil_awready_i;
    assign w_w_done   = !r_wvalid  || m_axil_wready_i;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state   <= c_st_idle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else if (cke_i) begin
            r_rvalid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (iob_avalid_i) begin
                        r_addr  <= iob_addr_i[ADDR_W-1:2];
                        r_wdata <= iob_wdata_i;
                        r_wstrb <= iob_wstrb_i;
                        if (w_is_write) begin
                            r_state   <= c_st_write;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state <= c_st_read;
                        end
                    end
                end
                c_st_write: begin
                    if (m_axil_awready_i) r_awvalid <= 1'b0;
                    if (m_axil_wready_i)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) r_state <= c_st_wresp;
                end
                c_st_wresp: begin
                    if (m_axil_bvalid_i) r_state <= c_st_idle;
                end
                c_st_read: begin
                    if (m_axil_arready_i) r_state <= c_st_rdata;
                end
                c_st_rdata: begin
                    if (m_axil_rvalid_i) begin
                        r_rdata  <= m_axil_rdata_i;
                        r_rvalid <= 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef IOB_IOB2AXIL_ERR_EN
    logic r_err;
    logic w_unused_addr;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_err <= 1'b0;
        end else if (cke_i) begin
            if ((r_state == c_st_wresp && m_axil_bvalid_i && resp_is_err(m_axil_bresp_i)) ||
                (r_state == c_st_rdata && m_axil_rvalid_i && resp_is_err(m_axil_rresp_i))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o         = r_err;
    assign w_unused_addr = ^iob_addr_i[1:0];
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{m_axil_bresp_i, m_axil_rresp_i, iob_addr_i[1:0]};
`endif

    assign iob_ready_o      = (r_state == c_st_idle);
    assign iob_rvalid_o     = r_rvalid;
    assign iob_rdata_o      = r_rdata;

    assign m_axil_awaddr_o  = {r_addr, 2'b00};
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = r_awvalid;
    assign m_axil_wdata_o   = r_wdata;
    assign m_axil_wstrb_o   = r_wstrb;
    assign m_axil_wvalid_o  = r_wvalid;
    assign m_axil_bready_o  = (r_state == c_st_wresp);
    assign m_axil_araddr_o  = {r_addr, 2'b00};
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_arvalid_o = (r_state == c_st_read);
    assign m_axil_rready_o  = (r_state == c_st_rdata);

endmodule
`default_nettype wire

// File: tb/tb_iob_iob2axil.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_iob2axil
// Description : Self-checking bench for iob_iob2axil with a delay-programmable
//               AXI4-Lite slave model and scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_iob2axil;
    import iob_iob2axil_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            arst;
    logic            cke;
    logic            iob_avalid;
    logic [AW-1:0]   iob_addr;
    logic [DW-1:0]   iob_wdata;
    logic [DW/8-1:0] iob_wstrb;
    logic            iob_ready;
    logic            iob_rvalid;
    logic [DW-1:0]   iob_rdata;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;
`ifdef IOB_IOB2AXIL_ERR_EN
    logic            err;
`endif

    always #5 clk = ~clk;

    iob_iob2axil #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke),
        .iob_avalid_i(iob_avalid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
        .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready), .iob_rvalid_o(iob_rvalid),
        .iob_rdata_o(iob_rdata),
        .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
        .m_axil_awready_i(awready), .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb),
        .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready), .m_axil_bresp_i(bresp),
        .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready), .m_axil_araddr_o(araddr),
        .m_axil_arprot_o(arprot), .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
        .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
        .m_axil_rready_o(rready)
`ifdef IOB_IOB2AXIL_ERR_EN
        , .err_o(err)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- AXI4-Lite slave model ----------------
    int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic        slv_clr;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_done, w_done, b_arm, r_arm;

    assign awready = awvalid && (aw_cnt >= cfg_aw_d);
    assign wready  = wvalid  && (w_cnt  >= cfg_w_d);
    assign arready = arvalid && (ar_cnt >= cfg_ar_d);
    assign bresp   = cfg_bresp;
    assign rresp   = cfg_rresp;

    always @(posedge clk) begin
        if (slv_clr) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_done <= 1'b0; w_done <= 1'b0; b_arm <= 1'b0; r_arm <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
        end else begin
            if (awvalid) aw_cnt <= awready ? 0 : aw_cnt + 1;
            if (wvalid)  w_cnt  <= wready  ? 0 : w_cnt + 1;
            if (arvalid) ar_cnt <= arready ? 0 : ar_cnt + 1;
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (cfg_b_d == 0) bvalid <= 1'b1;
                else begin b_arm <= 1'b1; b_cnt <= 1; end
            end
            if (b_arm) begin
                if (b_cnt >= cfg_b_d) begin bvalid <= 1'b1; b_arm <= 1'b0; end
                else b_cnt <= b_cnt + 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                if (cfg_r_d == 0) begin rvalid <= 1'b1; rdata <= cfg_rdata; end
                else begin r_arm <= 1'b1; r_cnt <= 1; end
            end
            if (r_arm) begin
                if (r_cnt >= cfg_r_d) begin rvalid <= 1'b1; rdata <= cfg_rdata; r_arm <= 1'b0; end
                else r_cnt <= r_cnt + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_aw[$], exp_ar[$], exp_rd[$];
    logic [35:0] exp_w[$];
    int          aw_hs_n = 0, ar_hs_n = 0;

    always @(negedge clk) begin
        if (arst) begin
            if (awvalid && awready) begin
                aw_hs_n++;
                chk("aw_expected", exp_aw.size() != 0, 1);
                if (exp_aw.size() != 0) chk("awaddr_prot", {awprot, awaddr}, {3'b000, exp_aw.pop_front()});
            end
            if (wvalid && wready) begin
                chk("w_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) chk("wdata_strb", {wdata, wstrb}, exp_w.pop_front());
            end
            if (arvalid && arready) begin
                ar_hs_n++;
                chk("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) chk("araddr_prot", {arprot, araddr}, {3'b000, exp_ar.pop_front()});
            end
            if (iob_rvalid) begin
                chk("rvalid_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) chk("iob_rdata", iob_rdata, exp_rd.pop_front());
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          aw_d, w_d, b_d, ar_d, r_d;
        int          lat;
    } vec_t;

    logic [31:0] last_rd = '0;

    task automatic drive_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] strb);
        iob_avalid = 1'b1;
        iob_addr   = addr;
        iob_wdata  = wd;
        iob_wstrb  = wr ? strb : 4'h0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int  got;
        bit  rv_seen;
        got = -1;
        rv_seen = 1'b0;
        cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
        cfg_ar_d = v.ar_d; cfg_r_d = v.r_d; cfg_rdata = v.rdata;
        if (v.wr) begin
            exp_aw.push_back({v.addr[31:2], 2'b00});
            exp_w.push_back({v.wdata, v.wstrb});
        end else begin
            exp_ar.push_back({v.addr[31:2], 2'b00});
            exp_rd.push_back(v.rdata);
        end
        @(negedge clk);
        chk({tag, "_ready_idle"}, iob_ready, 1);
        drive_req(v.wr, v.addr, v.wdata, v.wstrb);
        @(posedge clk); #1;
        iob_avalid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (v.wr) begin
                if (iob_rvalid) rv_seen = 1'b1;
                if (iob_ready) begin got = k; break; end
            end else if (iob_rvalid) begin
                got = k; break;
            end
        end
        chk({tag, "_latency"}, got, v.lat);
        if (v.wr) begin
            chk({tag, "_no_rvalid"}, rv_seen, 0);
            chk({tag, "_rdata_hold"}, iob_rdata, last_rd);
        end else begin
            last_rd = v.rdata;
            @(negedge clk);
            chk({tag, "_rvalid_1cyc"}, iob_rvalid, 0);
            chk({tag, "_rdata_hold"}, iob_rdata, v.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        vec_t        tv;
        logic [2:0]  exp028[5];
        int          ar0, aw0, got;
        logic        bad;

        vecs[0] = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 0, 0, 0, 3};
        vecs[1] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'h1234_5678, 0, 0, 0, 0, 4, 7};
        vecs[2] = '{1'b1, 32'h0000_0ABE, 32'h0102_0304, 4'h1, 32'h0, 2, 0, 1, 0, 0, 6};
        vecs[3] = '{1'b0, 32'h0000_0333, 32'h0,         4'h0, 32'hA5A5_5A5A, 0, 0, 0, 2, 0, 5};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D, 4'h8, 32'h0, 0, 0, 3, 0, 0, 6};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 5};
        exp028  = '{3'b110, 3'b010, 3'b010, 3'b010, 3'b001};

        arst = 1'b0; cke = 1'b1; slv_clr = 1'b1;
        iob_avalid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
        cfg_rdata = '0; cfg_bresp = c_resp_okay; cfg_rresp = c_resp_okay;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {iob_ready, awvalid, wvalid, bready, arvalid, rready, iob_rvalid}, 7'b1000000);
        chk("reset_rdata", iob_rdata, 0);
`ifdef IOB_IOB2AXIL_ERR_EN
        chk("reset_err", err, 0);
`endif
        slv_clr = 1'b0;
        @(posedge clk); #1;
        arst = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // awready first, wready three cycles later
        cfg_aw_d = 0; cfg_w_d = 3; cfg_b_d = 0;
        exp_aw.push_back(32'h0000_0400);
        exp_w.push_back({32'h5555_AAAA, 4'h3});
        @(negedge clk);
        drive_req(1'b1, 32'h0000_0400, 32'h5555_AAAA, 4'h3);
        @(posedge clk); #1;
        iob_avalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("split_c%0d_aw_w_b", c + 1), {awvalid, wvalid, bready}, exp028[c]);
        end
        @(negedge clk);
        chk("split_ready_back", iob_ready, 1);

        // second request while a read is busy must be ignored
        cfg_ar_d = 0; cfg_r_d = 4; cfg_rdata = 32'h0BAD_F00D;
        exp_ar.push_back(32'h0000_0800);
        exp_rd.push_back(32'h0BAD_F00D);
        ar0 = ar_hs_n; aw0 = aw_hs_n;
        @(negedge clk);
        drive_req(1'b0, 32'h0000_0800, 32'h0, 4'h0);
        @(posedge clk); #1;
        iob_avalid = 1'b0;
        @(negedge clk);
        chk("busy_ready_low", iob_ready, 0);
        drive_req(1'b1, 32'h0000_0500, 32'h1111_2222, 4'hF);
        @(negedge clk);
        @(negedge clk);
        iob_avalid = 1'b0;
        got = -1;
        for (int k = 3; k <= 40; k++) begin
            if (iob_rvalid) begin got = k; break; end
            @(negedge clk);
        end
        chk("busy_rd_latency", got, 7);
        last_rd = 32'h0BAD_F00D;
        @(negedge clk);
        chk("busy_rvalid_1cyc", iob_rvalid, 0);
        chk("busy_axi_counts", {ar_hs_n - ar0, aw_hs_n - aw0}, {32'd1, 32'd0});

        // clock enable low freezes IDLE acceptance
        ar0 = ar_hs_n;
        @(negedge clk);
        cke = 1'b0;
        drive_req(1'b0, 32'h0000_0600, 32'h0, 4'h0);
        @(negedge clk);
        chk("cke_hold_arvalid", arvalid, 0);
        iob_avalid = 1'b0;
        cke = 1'b1;
        @(negedge clk);
        chk("cke_no_txn", {arvalid, 32'(ar_hs_n - ar0)}, 33'd0);

        // reset while waiting in RDATA
        cfg_ar_d = 0; cfg_r_d = 6; cfg_rdata = 32'h7777_8888;
        exp_ar.push_back(32'h0000_0700);
        @(negedge clk);
        drive_req(1'b0, 32'h0000_0700, 32'h0, 4'h0);
        @(posedge clk); #1;
        iob_avalid = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rready) begin got = 1; break; end
        end
        chk("rst_reached_rdata", got, 1);
        arst = 1'b0;
        #1;
        chk("rst_mid_ctrl", {iob_ready, awvalid, wvalid, bready, arvalid, rready, iob_rvalid}, 7'b1000000);
        chk("rst_mid_rdata", iob_rdata, 0);
        @(posedge clk); #1;
        arst = 1'b1;
        last_rd = '0;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bad = bad | iob_rvalid | rready | !iob_ready;
        end
        chk("rst_late_rvalid_ignored", bad, 0);
        @(negedge clk);
        slv_clr = 1'b1;
        @(negedge clk);
        slv_clr = 1'b0;

        // error response handling
        cfg_bresp = c_resp_slverr;
        tv = '{1'b1, 32'h0000_0900, 32'h0F0F_0F0F, 4'hF, 32'h0, 0, 0, 0, 0, 0, 3};
        run_txn(tv, "slverr_wr");
        cfg_bresp = c_resp_okay;
`ifdef IOB_IOB2AXIL_ERR_EN
        chk("err_set", err, 1);
`endif
        tv = '{1'b0, 32'h0000_0A00, 32'h0, 4'h0, 32'h3C3C_C3C3, 0, 0, 0, 0, 0, 3};
        run_txn(tv, "okay_rd");
`ifdef IOB_IOB2AXIL_ERR_EN
        chk("err_sticky", err, 1);
`endif

        chk("queues_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iob_iob2axil.md
IOB_IOB2AXIL -- requirements
Module: iob_iob2axil

Interface
REQ-001 Parameter ADDR_W, default 32, IOb/AXI address width.
REQ-002 Parameter DATA_W, default 32, data width; DATA_W/8 strobe bits.
REQ-003 clk_i  input  1  system clock; one clock domain only.
REQ-004 arst_i  input  1  asynchronous, active-low reset.
REQ-005 cke_i  input  1  clock enable; when low, all state SHALL hold.
REQ-006 iob_avalid_i input 1, iob_addr_i input ADDR_W, iob_wdata_i input DATA_W, iob_wstrb_i input DATA_W/8: IOb native request from the external-memory data split; wstrb!=0 means write.
REQ-007 iob_ready_o output 1, iob_rvalid_o output 1, iob_rdata_o output DATA_W: IOb native response.
REQ-008 AXI4-Lite master: m_axil_aw{addr,valid,ready}, w{data,strb,valid,ready}, b{resp,valid,ready}, ar{addr,valid,ready}, r{data,resp,valid,ready}, standard widths and directions.

Function
REQ-009 FSM states SHALL be IDLE, WRITE, WRESP, READ, RDATA.
REQ-010 iob_ready_o SHALL be 1 only in IDLE; a request is accepted when iob_avalid_i && iob_ready_o.
REQ-011 On acceptance, the bridge SHALL register addr, wdata and wstrb, then enter WRITE (wstrb!=0) or READ (wstrb==0).
REQ-012 WRITE: awvalid and wvalid SHALL assert together; each SHALL drop independently after its own handshake; the FSM SHALL enter WRESP once both handshakes are done, including when both occur in the same cycle.
REQ-013 WRESP: bready=1; on bvalid, the FSM SHALL return to IDLE; writes SHALL NOT pulse iob_rvalid_o.
REQ-014 READ: arvalid=1 until arready, then enter RDATA.
REQ-015 RDATA: rready=1; on rvalid, iob_rdata_o SHALL capture rdata, iob_rvalid_o SHALL pulse high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-016 Minimum latency with always-ready slave: write 3 cycles, and read 3 cycles from acceptance to iob_rvalid_o.
REQ-017 AXI addresses SHALL be the registered IOb address, word-aligned (bits [1:0] forced to 0); awprot/arprot SHALL be 3'b000.
REQ-018 At most one outstanding transaction; iob_avalid_i outside IDLE SHALL be ignored.
REQ-019 iob_rdata_o SHALL hold its last captured value until the next read completes.

Reset
REQ-020 Reset SHALL force the FSM to IDLE and drive all AXI valid/ready outputs to 0, iob_rvalid_o to 0, iob_rdata_o to 0 and the error flag to 0; iob_ready_o SHALL be 1.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no IOb response, even if AXI handshakes are in flight.

Configuration
REQ-022 With macro IOB_IOB2AXIL_ERR_EN defined, output err_o (1 bit) SHALL set sticky on bresp/rresp != OKAY and clear only on reset.
REQ-023 Without IOB_IOB2AXIL_ERR_EN, err_o SHALL NOT exist and resp fields SHALL be ignored.

Structure
REQ-024 The FSM state encoding and AXI resp constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) SHALL live in shared package iob_iob2axil_pkg.
REQ-025 No sub-module; the FSM and registers SHALL be implemented inline.

Verification
REQ-026 Write 0x0000_0104 / 0xDEADBEEF / strb 0xF, slave always ready: awaddr=0x104, wdata=0xDEADBEEF, iob_ready_o back to 1 three cycles after acceptance, no rvalid.
REQ-027 Read 0x0000_0200, slave returns 0x12345678 after 4 wait cycles: exactly one iob_rvalid_o pulse with rdata=0x12345678.
REQ-028 Write with awready at cycle 1 and wready at cycle 4: awvalid drops after cycle 1, wvalid drops after cycle 4, bready asserts only afterwards.
REQ-029 Second avalid during a busy read: ignored, with no extra AXI transaction.
REQ-030 arst_i low while in RDATA: FSM returns to IDLE with all valid outputs 0, and a late rvalid produces no IOb pulse.
REQ-031 With IOB_IOB2AXIL_ERR_EN, bresp=SLVERR: err_o goes to 1 and stays 1 through later OKAY transactions.
